// File: rtl/run_ctrl.sv
// Run controller: loads a program start PC, holds the core in reset, then times its run.
// Optional watchdog enabled by defining RUN_CTRL_TIMEOUT_EN.
module run_ctrl #(
    parameter int unsigned RST_HOLD    = 2,
    parameter logic [7:0]  START_ADDR1 = 8'h00,
    parameter logic [7:0]  START_ADDR2 = 8'h40,
    parameter logic [7:0]  START_ADDR3 = 8'h80,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic        abort,
    input  logic        core_done,
    output logic        core_rst,
    output logic [7:0]  start_addr,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

`ifdef RUN_CTRL_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    // Watchdog compiled out: ERR unreachable and timeout stays 0.
    localparam logic TO_EN = 1'b0;
`endif

    logic [2:0]  state;
    logic [3:0]  hold_cnt;
    logic [7:0]  sel_addr;
    logic [15:0] cnt_nxt;
    logic        accept;
    logic        to_hit;

    always_comb begin
        sel_addr = 8'h00;
        case (prog_sel)
            2'd1:    sel_addr = START_ADDR1;
            2'd2:    sel_addr = START_ADDR2;
            2'd3:    sel_addr = START_ADDR3;
            default: sel_addr = 8'h00;
        endcase
    end

    assign cnt_nxt = (cycle_cnt == 16'hFFFF) ? cycle_cnt
                                             : cycle_cnt + 16'd1;
    assign accept  = start && (prog_sel != 2'd0);
    assign to_hit  = TO_EN && (cnt_nxt == TIMEOUT_CYC) && !core_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_cnt   <= 4'd0;
            core_rst   <= 1'b1;
            start_addr <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= 16'd0;
        end else begin
            unique case (state)
                S_IDLE, S_FIN, S_ERR: begin
                    if (accept) begin
                        state      <= S_LOAD;
                        hold_cnt   <= 4'd0;
                        core_rst   <= 1'b1;
                        start_addr <= sel_addr;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        cycle_cnt  <= 16'd0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= S_RUN;
                        core_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    // Abort beats a simultaneous core_done; count is kept as-is.
                    if (abort) begin
                        state    <= S_IDLE;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        cycle_cnt <= cnt_nxt;
                        if (core_done) begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (to_hit) begin
                            state    <= S_ERR;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            timeout  <= 1'b1;
                            core_rst <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a queue-based scoreboard of expected outputs.
// Watchdog checks follow RUN_CTRL_TIMEOUT_EN (TIMEOUT_CYC set to 20 here).
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  prog_sel;
    logic        abort;
    logic        core_done;
    logic        core_rst;
    logic [7:0]  start_addr;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_cnt;

    typedef struct {
        string       tag;
        logic        rst;
        logic [7:0]  addr;
        logic        bsy;
        logic        dn;
        logic        to;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    run_ctrl #(
        .RST_HOLD    (2),
        .START_ADDR1 (8'h00),
        .START_ADDR2 (8'h40),
        .START_ADDR3 (8'h80),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_sel   (prog_sel),
        .abort      (abort),
        .core_done  (core_done),
        .core_rst   (core_rst),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic r,
                        input logic [7:0] a, input logic b,
                        input logic d, input logic t,
                        input logic [15:0] c);
        exp_t e;
        e.tag = tag; e.rst = r; e.addr = a;
        e.bsy = b; e.dn = d; e.to = t; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic [27:0] got, want;
        e = sb.pop_front();
        got  = {core_rst, start_addr, busy, done, timeout, cycle_cnt};
        want = {e.rst, e.addr, e.bsy, e.dn, e.to, e.cnt};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: rst/addr/busy/done/to/cnt got %b/%h/%b/%b/%b/%0d want %b/%h/%b/%b/%b/%0d",
                   e.tag, core_rst, start_addr, busy, done, timeout, cycle_cnt,
                   e.rst, e.addr, e.bsy, e.dn, e.to, e.cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic r,
                        input logic [7:0] a, input logic b,
                        input logic d, input logic t,
                        input logic [15:0] c);
        push(tag, r, a, b, d, t, c);
        tick();
        check_pop();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_sel = 2'd0;
        abort = 1'b0; core_done = 1'b0;
        push("reset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
        repeat (2) tick();
        check_pop();
        reset = 1'b0;
        step("idle_after_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);

        // Program 1: two LOAD cycles, then 100 RUN cycles.
        start = 1'b1; prog_sel = 2'd1;
        step("load1_a", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        start = 1'b0; prog_sel = 2'd0;
        step("load1_b", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        core_done = 1'b1;
        step("run1_enter", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        core_done = 1'b0;
        for (int i = 1; i <= 99; i++) begin
            if (i == 11) begin
                start = 1'b1; prog_sel = 2'd2;
            end else begin
                start = 1'b0; prog_sel = 2'd0;
            end
            step("run1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'(i));
        end
        start = 1'b0; prog_sel = 2'd0;
        core_done = 1'b1;
        step("fin1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd100);
        core_done = 1'b0;
        abort = 1'b1;
        step("fin1_hold", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd100);
        abort = 1'b0;

        // Restart from FIN with program 3.
        start = 1'b1; prog_sel = 2'd3;
        step("load3", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 16'd0);
        start = 1'b0; prog_sel = 2'd0;
        step("load3_b", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 16'd0);
        step("run3", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 5; i++)
            step("run3_cnt", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 16'(i));

        // Abort and core_done together: abort wins, count retained.
        abort = 1'b1; core_done = 1'b1;
        step("abort_run", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd5);
        core_done = 1'b0;
        step("abort_idle", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd5);
        abort = 1'b0;
        start = 1'b1; prog_sel = 2'd0;
        step("sel0_ignored", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 16'd5);

        // Abort during LOAD.
        prog_sel = 2'd2;
        step("load2", 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        start = 1'b0; prog_sel = 2'd0; abort = 1'b1;
        step("abort_load", 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 16'd0);
        abort = 1'b0;

        // Watchdog window.
        start = 1'b1; prog_sel = 2'd2;
        step("load2_to", 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        start = 1'b0; prog_sel = 2'd0;
        step("load2_to_b", 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        step("run2_to", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 19; i++)
            step("run2_to_cnt", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'(i));
`ifdef RUN_CTRL_TIMEOUT_EN
        step("err", 1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 16'd20);
        abort = 1'b1;
        step("err_hold", 1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 16'd20);
        abort = 1'b0;
        start = 1'b1; prog_sel = 2'd2;
        step("load_from_err", 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        start = 1'b0; prog_sel = 2'd0;
        step("load_from_err_b", 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        step("run_race", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 19; i++)
            step("run_race_cnt", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'(i));
        core_done = 1'b1;
        step("fin_race", 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 16'd20);
        core_done = 1'b0;
`else
        step("no_to_20", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'd20);
        step("no_to_21", 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'd21);
        core_done = 1'b1;
        step("fin_no_to", 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 16'd22);
        core_done = 1'b0;
`endif

        // Reset mid-run acts without a clock edge.
        start = 1'b1; prog_sel = 2'd1;
        step("load_rst", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        start = 1'b0; prog_sel = 2'd0;
        step("load_rst_b", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        step("run_rst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 7; i++)
            step("run_rst_cnt", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'(i));
        push("async_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
        #1 reset = 1'b1;
        #1 check_pop();
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_HOLD, default 2: number of cycles core_rst is held in LOAD (legal range 1..15).
REQ-002 Parameter START_ADDR1, default 8'h00: core start PC for program 1.
REQ-003 Parameter START_ADDR2, default 8'h40: core start PC for program 2.
REQ-004 Parameter START_ADDR3, default 8'h80: core start PC for program 3.
REQ-005 Parameter TIMEOUT_CYC, default 16'd50000: RUN cycles allowed before timeout (used only with RUN_CTRL_TIMEOUT_EN).
REQ-006 Port clk  input  1  single clock; all state changes on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port start  input  1  level-sampled request to launch program prog_sel.
REQ-009 Port prog_sel  input  2  program select: 1, 2 or 3; 0 is invalid.
REQ-010 Port abort  input  1  cancel the run in progress.
REQ-011 Port core_done  input  1  done flag from the core.
REQ-012 Port core_rst  output  1  reset to the core; 1 holds the core at start_addr.
REQ-013 Port start_addr  output  8  PC the core loads while core_rst=1.
REQ-014 Port busy  output  1  1 in LOAD and RUN.
REQ-015 Port done  output  1  run finished, normally or by timeout.
REQ-016 Port timeout  output  1  last run ended by watchdog.
REQ-017 Port cycle_cnt  output  16  RUN-state cycles of the last or current run.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN, FIN and ERR; all outputs SHALL be registered.
REQ-019 In IDLE, FIN or ERR, start=1 with prog_sel!=0 SHALL latch start_addr from the table, clear cycle_cnt, done and timeout, and enter LOAD on that edge.
REQ-020 If prog_sel=0, start SHALL be ignored and the state SHALL not change.
REQ-021 start in LOAD or RUN SHALL be ignored.
REQ-022 LOAD SHALL hold core_rst=1 and busy=1 for exactly RST_HOLD cycles, then enter RUN.
REQ-023 core_done SHALL be ignored in LOAD.
REQ-024 RUN SHALL drive core_rst=0 and busy=1.
REQ-025 In RUN, cycle_cnt SHALL increment on every edge, saturating at 16'hFFFF.
REQ-026 In RUN, core_done=1 SHALL move to FIN on that edge; that edge SHALL still increment cycle_cnt.
REQ-027 FIN SHALL drive done=1, busy=0 and core_rst=0 (the core is left halted); cycle_cnt SHALL freeze.
REQ-028 abort=1 in LOAD or RUN SHALL enter IDLE on the next edge with core_rst=1, busy=0 and done=0; cycle_cnt SHALL be retained.
REQ-029 abort SHALL have no effect in IDLE, FIN or ERR.
REQ-030 If abort and core_done are high on the same RUN edge, abort SHALL win.
REQ-031 start_addr SHALL remain stable from LOAD until the next accepted start.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE with core_rst=1, start_addr=0, busy=0, done=0, timeout=0 and cycle_cnt=0.
REQ-033 Assertion of reset mid-run SHALL immediately reassert core_rst.
REQ-034 Deassertion of reset SHALL take effect at the next rising clk edge.

Configuration
REQ-035 With macro RUN_CTRL_TIMEOUT_EN defined: on the RUN edge where cycle_cnt reaches TIMEOUT_CYC with core_done=0, the block SHALL enter ERR with done=1, timeout=1, busy=0 and core_rst=1.
REQ-036 With RUN_CTRL_TIMEOUT_EN defined: if core_done=1 on that same edge, the block SHALL enter FIN and timeout SHALL stay 0.
REQ-037 Without RUN_CTRL_TIMEOUT_EN: ERR SHALL be unreachable, timeout SHALL be tied to 0, and RUN SHALL wait indefinitely for core_done.

Verification
REQ-038 Reset, then start=1 with prog_sel=1 for 1 cycle -> start_addr=8'h00, core_rst=1 for 2 cycles, then 0; core_done raised after 100 RUN cycles -> done=1, cycle_cnt=100.
REQ-039 From FIN, start with prog_sel=3 -> done clears the next cycle, start_addr=8'h80, cycle_cnt restarts from 0.
REQ-040 start with prog_sel=0 in IDLE -> no change; start while in RUN -> ignored, cycle_cnt keeps counting.
REQ-041 abort and core_done high on the same RUN edge -> IDLE, done=0, core_rst=1.
REQ-042 With RUN_CTRL_TIMEOUT_EN and TIMEOUT_CYC=20, core_done never asserted -> ERR at cycle_cnt=20 with timeout=1, done=1, core_rst=1; repeat with core_done on the 20th RUN edge -> FIN, timeout=0.
REQ-043 Assert reset in the middle of RUN -> core_rst=1 and cycle_cnt=0 immediately, without waiting for a clock edge.
